// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor for IEEE-754-style operands.
// Rounding is round-to-nearest-even, subnormals are flushed to zero, and the whole pipe stalls on output backpressure.
`timescale 1ns/1ps
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam logic [EXP_W-1:0]      EMAX   = '1;
  localparam logic [W-1:0]          QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [31:0]           SH_LIM = 32'(MAN_W + 3);
  localparam logic signed [EW2-1:0] EZERO  = '0;
  localparam logic signed [EW2-1:0] EONE   = EW2'(1);
  localparam logic signed [EW2-1:0] EMAXS  = signed'({2'b00, EMAX});

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // S1: unpack, classify, order by magnitude
  logic             w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [W-2:0]     w_mag_a, w_mag_b;
  logic [MAN_W:0]   w_ma, w_mb;
  logic             w_spec, w_spec_inv;
  logic [W-1:0]     w_spec_res;

  assign w_sa     = a[W-1];
  assign w_sb     = b[W-1] ^ op_sub;
  assign w_ea     = a[W-2:MAN_W];
  assign w_eb     = b[W-2:MAN_W];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (w_ea == EMAX) && (a[MAN_W-1:0] != '0);
  assign w_b_nan  = (w_eb == EMAX) && (b[MAN_W-1:0] != '0);
  assign w_a_inf  = (w_ea == EMAX) && (a[MAN_W-1:0] == '0);
  assign w_b_inf  = (w_eb == EMAX) && (b[MAN_W-1:0] == '0);
  assign w_mag_a  = w_a_zero ? '0 : a[W-2:0];
  assign w_mag_b  = w_b_zero ? '0 : b[W-2:0];
  assign w_ma     = w_a_zero ? '0 : {1'b1, a[MAN_W-1:0]};
  assign w_mb     = w_b_zero ? '0 : {1'b1, b[MAN_W-1:0]};
  assign w_swap   = (w_mag_b > w_mag_a);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
    end else if (w_a_inf && w_b_inf) begin
      if (w_sa == w_sb) w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
      else begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end
    end else if (w_a_inf) begin
      w_spec_res = {w_sa, EMAX, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_sb, EMAX, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      // two zeros only stay negative when both are negative
      w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  logic             r1_valid, r1_sx, r1_sy, r1_spec, r1_spec_inv;
  logic [EXP_W-1:0] r1_ex, r1_d;
  logic [MAN_W:0]   r1_mx, r1_my;
  logic [W-1:0]     r1_spec_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_sx       <= w_swap ? w_sb : w_sa;
      r1_sy       <= w_swap ? w_sa : w_sb;
      r1_ex       <= w_swap ? w_eb : w_ea;
      r1_d        <= w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
      r1_mx       <= w_swap ? w_mb : w_ma;
      r1_my       <= w_swap ? w_ma : w_mb;
      r1_spec     <= w_spec;
      r1_spec_inv <= w_spec_inv;
      r1_spec_res <= w_spec_res;
    end
  end

  // S2: align smaller significand with guard/round/sticky, then add or subtract
  logic [2*SW-1:0] w_sh;
  logic [SW-1:0]   w_al;
  logic [SW:0]     w_sum;

  assign w_sh = {r1_my, 3'b000, {SW{1'b0}}} >> r1_d;

  always_comb begin
    if (32'(r1_d) >= SH_LIM) w_al = {{(SW-1){1'b0}}, |r1_my};
    else                     w_al = {w_sh[2*SW-1:SW+1], w_sh[SW] | (|w_sh[SW-1:0])};
    if (r1_sx ^ r1_sy) w_sum = {1'b0, r1_mx, 3'b000} - {1'b0, w_al};
    else               w_sum = {1'b0, r1_mx, 3'b000} + {1'b0, w_al};
  end

  logic             r2_valid, r2_sign, r2_spec, r2_spec_inv;
  logic [EXP_W-1:0] r2_exp;
  logic [SW:0]      r2_sum;
  logic [W-1:0]     r2_spec_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
    end else if (w_adv) begin
      r2_valid    <= r1_valid;
      r2_sign     <= r1_sx;
      r2_exp      <= r1_ex;
      r2_sum      <= w_sum;
      r2_spec     <= r1_spec;
      r2_spec_inv <= r1_spec_inv;
      r2_spec_res <= r1_spec_res;
    end
  end

  // S3: normalize, round to nearest even, pack
  logic [EW2-1:0]        w_lz;
  logic signed [EW2-1:0] w_exp_n, w_exp_f;
  logic [SW-1:0]         w_norm;
  logic                  w_rup;
  logic [MAN_W+1:0]      w_mant_r;
  logic [MAN_W-1:0]      w_frac;
  logic [W-1:0]          w_res;
  logic                  w_ovf, w_unf, w_inv;

  always_comb begin
    w_lz = '0;
    for (int unsigned i = 0; i < SW; i++)
      if (r2_sum[i]) w_lz = EW2'(SW - 1 - i);
    if (r2_sum[SW]) begin
      w_norm  = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = signed'({2'b00, r2_exp}) + EONE;
    end else begin
      w_norm  = r2_sum[SW-1:0] << w_lz;
      w_exp_n = signed'({2'b00, r2_exp}) - signed'(w_lz);
    end
    w_rup    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r = {1'b0, w_norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
    if (w_mant_r[MAN_W+1]) begin
      w_exp_f = w_exp_n + EONE;
      w_frac  = w_mant_r[MAN_W:1];
    end else begin
      w_exp_f = w_exp_n;
      w_frac  = w_mant_r[MAN_W-1:0];
    end
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    if (r2_spec) begin
      w_res = r2_spec_res;
      w_inv = r2_spec_inv;
    end else if (r2_sum == '0) begin
      w_res = '0;
    end else if (w_exp_n <= EZERO) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end else if (w_exp_f >= EMAXS) begin
      w_res = {r2_sign, EMAX, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else begin
      w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r2_valid;
      result    <= w_res;
      overflow  <= w_ovf;
      underflow <= w_unf;
      invalid   <= w_inv;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: single-precision and half-precision instances.
// Covers rounding, specials, backpressure ordering and mid-flight reset.
`timescale 1ns/1ps
module tb_fp_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready, ovf, unf, inv;
  logic [31:0] a, b, result;
  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready, h_ovf, h_unf, h_inv;
  logic [15:0] h_a, h_b, h_result;

  int n_cmp = 0;
  int n_err = 0;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(ovf), .underflow(unf), .invalid(inv)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op_sub(h_op_sub),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .overflow(h_ovf), .underflow(h_unf), .invalid(h_inv)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic sub, input logic [31:0] want, input logic [2:0] wflags);
    int lat;
    bit got;
    @(negedge clk);
    a = ia; b = ib; op_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd3);
    check_val({tag, "_res"}, result, want);
    check_val({tag, "_flg"}, 32'({ovf, unf, inv}), 32'(wflags));
  endtask

  task automatic run_op_h(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic sub, input logic [15:0] want, input logic [2:0] wflags);
    int lat;
    bit got;
    @(negedge clk);
    h_a = ia; h_b = ib; h_op_sub = sub; h_in_valid = 1'b1;
    @(posedge clk);
    #1 h_in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = h_out_valid;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd3);
    check_val({tag, "_res"}, 32'(h_result), 32'(want));
    check_val({tag, "_flg"}, 32'({h_ovf, h_unf, h_inv}), 32'(wflags));
  endtask

  logic [31:0] bp_b [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_w [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ii, oo, cyc, extra;
    bit mv1, mv2, mv3, adv, acc;

    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_op_sub = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ov", 32'(out_valid), 32'd0);
    check_val("rst_res", result, 32'h0);
    check_val("rst_flg", 32'({ovf, unf, inv}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_rdy", 32'(in_ready), 32'd1);

    run_op("one_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run_op("tie_up",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000);
    run_op("sticky",    32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000);
    run_op("far_shift", 32'h3F800000, 32'h0B800000, 1'b0, 32'h3F800000, 3'b000);
    run_op("rnd_carry", 32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 3'b000);
    run_op("cancel",    32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000);
    run_op("opp_sign",  32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
    run_op("sub_norm",  32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000);
    run_op("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001);
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001);
    run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    run_op("unf",       32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b010);
    run_op("nan_in",    32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
    run_op("ninf_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
    run_op("pz_pz",     32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    run_op("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    run_op("subn_in",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b000);

    // six back-to-back operands with a four-cycle output stall; valids tracked by a small model
    ii = 0; oo = 0; cyc = 0; mv1 = 1'b0; mv2 = 1'b0; mv3 = 1'b0;
    @(negedge clk);
    a = 32'h3F800000; b = bp_b[0]; op_sub = 1'b0; in_valid = 1'b1;
    while (oo < 6 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      adv = !mv3 || out_ready;
      #1;
      check_val("bp_rdy", 32'(in_ready), 32'(adv));
      check_val("bp_ov", 32'(out_valid), 32'(mv3));
      if (mv3) begin
        if (out_ready) begin
          check_val("bp_res", result, bp_w[oo]);
          oo++;
        end else begin
          check_val("bp_hold", result, bp_w[oo]);
        end
      end
      acc = in_valid && adv;
      if (adv) begin
        mv3 = mv2; mv2 = mv1; mv1 = acc;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        ii++;
        if (ii < 6) b = bp_b[ii];
        else in_valid = 1'b0;
      end
    end
    check_val("bp_count", 32'(oo), 32'd6);
    out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_val("bp_extra", 32'(extra), 32'd0);

    // two operations in flight when reset hits
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(negedge clk);
    b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mrst_ov", 32'(out_valid), 32'd0);
    check_val("mrst_res", result, 32'h0);
    check_val("mrst_rdy", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_val("mrst_none", 32'(extra), 32'd0);

    run_op_h("h_one",   16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
    run_op_h("h_three", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);
    run_op_h("h_sub",   16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
    run_op_h("h_ovf",   16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored-fraction width. Operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, operands presented.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 The block SHALL have port op_sub, input, 1, 0 = a+b, 1 = a-b (sign of b inverted).
REQ-008 The block SHALL have ports a and b, input, W each, IEEE-754-style operands {sign, exponent, fraction}.
REQ-009 The block SHALL have port out_valid, output, 1, result available.
REQ-010 The block SHALL have port out_ready, input, 1, downstream consumes result.
REQ-011 The block SHALL have port result, output, W, rounded sum.
REQ-012 The block SHALL have ports overflow, underflow and invalid, output, 1 each, flags qualified by out_valid.

Function
REQ-013 The block SHALL implement a 3-stage pipeline: S1 unpack/classify/compare/swap, S2 align/add-or-subtract, S3 normalize/round/pack.
REQ-014 The block SHALL compute advance = !out_valid | out_ready and drive in_ready = advance; when advance=0, all stages SHALL hold.
REQ-015 The block SHALL accept a transfer when in_valid & in_ready; with advance held at 1, out_valid SHALL rise exactly 3 cycles after acceptance.
REQ-016 The block SHALL propagate bubbles so that out_valid is 0 for cycles with no corresponding accepted input; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-017 S1 SHALL order operands by magnitude ({exp,frac} compare), with the larger as X; exponent difference d = eX-eY.
REQ-018 S2 SHALL right-shift the smaller significand (hidden bit included) by d into a MAN_W+4-bit datapath with guard, round and sticky, where sticky = OR of all shifted-out bits; for d >= MAN_W+3, the whole significand SHALL go to sticky.
REQ-019 S2 SHALL add significands on equal effective signs, otherwise subtract (X-Y); result sign = sign of X.
REQ-020 S3 SHALL normalize a carry-out by a right shift of 1 with exponent +1, and cancellation by leading-zero count with the matching left shift and exponent decrement.
REQ-021 S3 SHALL round to nearest, ties to even; a rounding carry SHALL renormalize and increment the exponent.
REQ-022 A biased exponent reaching all-ones after rounding SHALL produce signed infinity with overflow=1.
REQ-023 A normalized exponent <= 0 SHALL flush to signed zero with underflow=1; subnormal inputs (exp=0) SHALL be treated as zero on input.
REQ-024 An exact zero difference SHALL yield +0; (+0)+(+0) SHALL yield +0 and (-0)+(-0) SHALL yield -0.
REQ-025 Any NaN input SHALL yield canonical quiet NaN {0, all-ones, 1, 0...}; inf + -inf (effective) SHALL yield canonical NaN with invalid=1.
REQ-026 Inf plus finite SHALL yield that infinity with all flags 0.
REQ-027 The flags SHALL be mutually exclusive per result.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL clear all stage valid bits; out_valid=0, result=0, overflow=underflow=invalid=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-030 Check: a=0x3F800000, b=0x3F800000, op_sub=0, out_ready=1 -> 3 cycles later result=0x40000000, flags 0.
REQ-031 Check rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800000+0x33C00000 -> 0x3F800001.
REQ-032 Check cancellation and special cases: 0x3FC00000 with op_sub=1, same operand -> 0x00000000; 0x7F800000+0xFF800000 -> 0x7FC00000, invalid=1.
REQ-033 Check overflow: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1.
REQ-034 Check backpressure: stream 6 back-to-back inputs, drop out_ready for 4 cycles mid-stream -> in_ready follows advance, all 6 results in order, none lost, each held stable while stalled.
REQ-035 Check parametrisation and reset: EXP_W=5, MAN_W=10, 0x3C00+0x3C00 -> 0x4000; separately, rst pulsed with 2 ops in flight -> no out_valid for those ops.
